// File: rtl/bscan_user_dr_ctrl.sv
// bscan_user_dr_ctrl: BSCANE2 user data register, oversampled in the fabric clk domain
//   clk, rst                 fabric clock, synchronous active-high reset
//   tck, tdi                 raw JTAG clock/data from BSCANE2
//   ir_is_user               BSCANE2 SEL
//   test_logic_reset         BSCANE2 RESET
//   capture_dr/shift_dr/update_dr  BSCANE2 CAPTURE/SHIFT/UPDATE
//   tdo                      registered DR LSB back to BSCANE2
//   cap_data                 word loaded into the DR at capture
//   upd_data, upd_valid, upd_ready  committed word with valid/ready handshake
//   short_err, ovf_err, err_clr     sticky error flags and their clear pulse
module bscan_user_dr_ctrl #(
   parameter int DR_WIDTH    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tck,
   input  logic                tdi,
   input  logic                ir_is_user,
   input  logic                test_logic_reset,
   input  logic                capture_dr,
   input  logic                shift_dr,
   input  logic                update_dr,
   output logic                tdo,
   input  logic [DR_WIDTH-1:0] cap_data,
   output logic [DR_WIDTH-1:0] upd_data,
   output logic                upd_valid,
   input  logic                upd_ready,
   output logic                short_err,
   output logic                ovf_err,
   input  logic                err_clr
);
   localparam int CW = $clog2(DR_WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   state_t state;
   // every JTAG input rides the same chain so controls stay aligned with tck
   logic [6:0] sync [SYNC_STAGES];
   logic tck_prev;
   logic [DR_WIDTH-1:0] sr;
   logic [CW-1:0] bit_cnt;
   logic tck_s, tdi_s, sel_s, tlr_s, cap_s, sh_s, upd_s;
   logic tck_rise, full, load, short_set, ovf_set;
   assign {upd_s, sh_s, cap_s, tlr_s, sel_s, tdi_s, tck_s} = sync[SYNC_STAGES-1];
   assign tck_rise  = tck_s & ~tck_prev;
   assign full      = bit_cnt == CW'(DR_WIDTH);
   // a consumer accepting in the commit cycle frees the slot for the new word
   assign load      = state == COMMIT && full && (!upd_valid || upd_ready);
   assign short_set = state == COMMIT && !full;
   assign ovf_set   = state == COMMIT && full && upd_valid && !upd_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
         tck_prev  <= 1'b0;
         state     <= IDLE;
         sr        <= '0;
         bit_cnt   <= '0;
         tdo       <= 1'b0;
         upd_data  <= '0;
         upd_valid <= 1'b0;
         short_err <= 1'b0;
         ovf_err   <= 1'b0;
      end else begin
         sync[0] <= {update_dr, shift_dr, capture_dr, test_logic_reset, ir_is_user, tdi, tck};
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
         tck_prev  <= tck_s;
         tdo       <= sr[0];
         short_err <= short_set | (short_err & ~err_clr);
         ovf_err   <= ovf_set | (ovf_err & ~err_clr);
         if (load) begin
            upd_data  <= sr;
            upd_valid <= 1'b1;
         end else if (upd_valid && upd_ready) begin
            upd_valid <= 1'b0;
         end
         if (tlr_s) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
         end else begin
            case (state)
               IDLE: if (tck_rise && sel_s && cap_s) begin
                  state   <= SHIFT;
                  sr      <= cap_data;
                  bit_cnt <= '0;
               end
               SHIFT: if (!sel_s) begin
                  state <= IDLE;
               end else if (tck_rise && cap_s) begin
                  sr      <= cap_data;
                  bit_cnt <= '0;
               end else if (tck_rise && sh_s) begin
                  sr <= {tdi_s, sr[DR_WIDTH-1:1]};
                  if (!full) bit_cnt <= bit_cnt + 1'b1;
               end else if (tck_rise && upd_s) begin
                  state <= COMMIT;
               end
               COMMIT: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bscan_user_dr_ctrl.sv
// tb_bscan_user_dr_ctrl: directed bench for bscan_user_dr_ctrl
module tb_bscan_user_dr_ctrl;
   localparam int W = 32;
   logic clk = 1'b0;
   logic rst, tck, tdi, ir_is_user, test_logic_reset, capture_dr, shift_dr, update_dr;
   logic tdo, upd_valid, upd_ready, short_err, ovf_err, err_clr;
   logic [W-1:0] cap_data, upd_data;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   bscan_user_dr_ctrl #(.DR_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .tck(tck), .tdi(tdi), .ir_is_user(ir_is_user),
      .test_logic_reset(test_logic_reset), .capture_dr(capture_dr), .shift_dr(shift_dr),
      .update_dr(update_dr), .tdo(tdo), .cap_data(cap_data), .upd_data(upd_data),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .short_err(short_err),
      .ovf_err(ovf_err), .err_clr(err_clr)
   );
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic jcyc(input logic c, input logic s, input logic u, input logic d);
      capture_dr = c; shift_dr = s; update_dr = u; tdi = d;
      step(4); tck = 1'b1; step(6); tck = 1'b0; step(6);
   endtask
   task automatic capture(input logic [W-1:0] d);
      cap_data = d;
      jcyc(1'b1, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic shift(input logic [W-1:0] v, input int n);
      for (int i = 0; i < n; i++) jcyc(1'b0, 1'b1, 1'b0, v[i]);
   endtask
   task automatic update();
      jcyc(1'b0, 1'b0, 1'b1, 1'b0);
   endtask
   task automatic xact(input logic [W-1:0] c, input logic [W-1:0] v);
      capture(c); shift(v, W); update();
   endtask
   task automatic drain();
      upd_ready = 1'b1; step(1); upd_ready = 1'b0; step(1);
   endtask
   task automatic pulse_clr();
      err_clr = 1'b1; step(1); err_clr = 1'b0; step(1);
   endtask
   task automatic tlr_pulse();
      test_logic_reset = 1'b1; step(4); test_logic_reset = 1'b0; step(4);
   endtask
   task automatic test_reset();
      total++; if (tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%0b want=0", tdo); end
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", upd_valid); end
      total++; if (upd_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", upd_data); end
      total++; if (short_err !== 1'b0) begin bad++; $display("FAIL reset_short got=%0b want=0", short_err); end
      total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", ovf_err); end
   endtask
   task automatic test_full();
      logic [W-1:0] c, v;
      c = 32'hA5A5_0F0F; v = 32'h1234_5678;
      capture(c);
      for (int i = 0; i < W; i++) begin
         total++; if (tdo !== c[i]) begin bad++; $display("FAIL full_tdo bit=%0d got=%0b want=%0b", i, tdo, c[i]); end
         jcyc(1'b0, 1'b1, 1'b0, v[i]);
      end
      update();
      total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%0b want=1", upd_valid); end
      total++; if (upd_data !== v) begin bad++; $display("FAIL full_data got=%h want=%h", upd_data, v); end
      total++; if (short_err !== 1'b0) begin bad++; $display("FAIL full_short got=%0b want=0", short_err); end
      drain();
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL full_drain got=%0b want=0", upd_valid); end
   endtask
   task automatic test_short();
      capture(32'h0); shift(32'hFFFF_FFFF, W - 1); update();
      total++; if (short_err !== 1'b1) begin bad++; $display("FAIL short_set got=%0b want=1", short_err); end
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL short_valid got=%0b want=0", upd_valid); end
      pulse_clr();
      total++; if (short_err !== 1'b0) begin bad++; $display("FAIL short_clr got=%0b want=0", short_err); end
   endtask
   task automatic test_overflow();
      xact(32'h0, 32'h1111_1111);
      xact(32'h0, 32'h2222_2222);
      total++; if (upd_data !== 32'h1111_1111) begin bad++; $display("FAIL ovf_data got=%h want=11111111", upd_data); end
      total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", ovf_err); end
      total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%0b want=1", upd_valid); end
      drain();
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%0b want=0", upd_valid); end
      pulse_clr();
      total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0b want=0", ovf_err); end
   endtask
   task automatic test_back_to_back();
      xact(32'h0, 32'h1111_1111);
      capture(32'h0); shift(32'h2222_2222, W);
      // sync(2) + edge detect puts COMMIT on the 3rd clk after tck rises
      capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b1;
      step(4); tck = 1'b1; step(3); upd_ready = 1'b1; step(1); upd_ready = 1'b0; step(2); tck = 1'b0; step(6);
      total++; if (upd_data !== 32'h2222_2222) begin bad++; $display("FAIL b2b_data got=%h want=22222222", upd_data); end
      total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b want=1", upd_valid); end
      total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%0b want=0", ovf_err); end
      drain();
   endtask
   task automatic test_tlr();
      xact(32'h0, 32'hCAFE_F00D);
      capture(32'hFFFF_FFFF); shift(32'hFFFF_FFFF, 10);
      tlr_pulse();
      total++; if (tdo !== 1'b0) begin bad++; $display("FAIL tlr_tdo got=%0b want=0", tdo); end
      total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL tlr_valid got=%0b want=1", upd_valid); end
      total++; if (upd_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL tlr_data got=%h want=cafef00d", upd_data); end
      drain();
      xact(32'h0, 32'h89AB_CDEF);
      total++; if (upd_data !== 32'h89AB_CDEF) begin bad++; $display("FAIL tlr_after got=%h want=89abcdef", upd_data); end
      total++; if (short_err !== 1'b0) begin bad++; $display("FAIL tlr_short got=%0b want=0", short_err); end
      drain();
   endtask
   task automatic test_sel_drop();
      capture(32'h0); shift(32'h5555_AAAA, W);
      ir_is_user = 1'b0; step(6); ir_is_user = 1'b1; step(2);
      update();
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL seldrop_valid got=%0b want=0", upd_valid); end
      total++; if (short_err !== 1'b0) begin bad++; $display("FAIL seldrop_short got=%0b want=0", short_err); end
   endtask
   task automatic test_unselected();
      tlr_pulse();
      ir_is_user = 1'b0;
      capture(32'hFFFF_FFFF); shift(32'hFFFF_FFFF, W); update();
      total++; if (tdo !== 1'b0) begin bad++; $display("FAIL unsel_tdo got=%0b want=0", tdo); end
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL unsel_valid got=%0b want=0", upd_valid); end
      total++; if (short_err !== 1'b0) begin bad++; $display("FAIL unsel_short got=%0b want=0", short_err); end
      ir_is_user = 1'b1;
   endtask
   task automatic test_rst_mid_shift();
      xact(32'h0, 32'h0BAD_BEEF);
      capture(32'hFFFF_FFFF); shift(32'hFFFF_FFFF, 5);
      rst = 1'b1; step(1); rst = 1'b0; step(2);
      total++; if (tdo !== 1'b0) begin bad++; $display("FAIL rst_tdo got=%0b want=0", tdo); end
      total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", upd_valid); end
      total++; if (upd_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=00000000", upd_data); end
      xact(32'h0, 32'h600D_F00D);
      total++; if (upd_data !== 32'h600D_F00D) begin bad++; $display("FAIL rst_after got=%h want=600df00d", upd_data); end
      total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL rst_after_valid got=%0b want=1", upd_valid); end
      drain();
   endtask
   initial begin
      rst = 1'b1; tck = 1'b0; tdi = 1'b0; ir_is_user = 1'b1; test_logic_reset = 1'b0;
      capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; cap_data = '0;
      upd_ready = 1'b0; err_clr = 1'b0;
      step(3); rst = 1'b0; step(2);
      test_reset();
      test_full();
      test_short();
      test_overflow();
      test_back_to_back();
      test_tlr();
      test_sel_drop();
      test_unselected();
      test_rst_mid_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bscan_user_dr_ctrl.md
BSCAN_USER_DR_CTRL -- requirements
Module: bscan_user_dr_ctrl

Interface
REQ-001 SHALL have parameter DR_WIDTH, default 32, user data register length in bits (legal 8..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for all JTAG inputs (legal 2..4).
REQ-003 SHALL use one clock and a synchronous, active-high reset; no other clock or reset ports.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  fabric sampling clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- tck  in  1  raw JTAG TCK from BSCANE2.
- tdi  in  1  raw JTAG TDI.
- ir_is_user  in  1  BSCANE2 SEL.
- test_logic_reset  in  1  BSCANE2 RESET.
- capture_dr  in  1  BSCANE2 CAPTURE.
- shift_dr  in  1  BSCANE2 SHIFT.
- update_dr  in  1  BSCANE2 UPDATE.
- tdo  out  1  to BSCANE2 TDO.
- cap_data  in  DR_WIDTH  word loaded into the DR at capture.
- upd_data  out  DR_WIDTH  committed DR word.
- upd_valid  out  1  upd_data valid; held until accepted.
- upd_ready  in  1  consumer accept.
- short_err  out  1  sticky: update with fewer than DR_WIDTH shifts.
- ovf_err  out  1  sticky: commit dropped because output was still pending.
- err_clr  in  1  one-cycle pulse clearing short_err and ovf_err.

Function
REQ-005 SHALL pass tck, tdi, ir_is_user, test_logic_reset, capture_dr, shift_dr and update_dr through SYNC_STAGES flops each.
REQ-006 SHALL detect a TCK rising edge as synchronized tck high while its previous sample was low, giving a one-cycle tck_rise pulse.
REQ-007 Latency: a tck edge at the pins SHALL act on internal state SYNC_STAGES+1 clk cycles later; clk SHALL be at least 4x TCK frequency.
REQ-008 FSM states: IDLE, SHIFT, COMMIT; encoding is free.
REQ-009 IDLE -> SHIFT on tck_rise with sel&capture: load sr <= cap_data and bit_cnt <= 0.
REQ-010 SHIFT, on tck_rise with sel&shift: sr <= {tdi_sync, sr[DR_WIDTH-1:1]} (LSB out first); bit_cnt increments, saturating at DR_WIDTH.
REQ-011 SHIFT -> COMMIT on tck_rise with sel&update; SHIFT -> SHIFT on tck_rise with sel&capture (reload, bit_cnt <= 0).
REQ-012 COMMIT SHALL last exactly one cycle, then return to IDLE.
REQ-013 In COMMIT with bit_cnt < DR_WIDTH: set short_err; no output update.
REQ-014 In COMMIT with bit_cnt == DR_WIDTH and upd_valid==0, or upd_valid&upd_ready in the same cycle: upd_data <= sr, upd_valid <= 1.
REQ-015 In COMMIT with bit_cnt == DR_WIDTH and upd_valid&!upd_ready: set ovf_err; drop the new word; upd_data is unchanged.
REQ-016 Outside a loading COMMIT, upd_valid SHALL clear on the cycle after upd_valid&upd_ready; upd_data SHALL stay stable while upd_valid is 1.
REQ-017 tck_rise while sel is low SHALL be ignored in every state.
REQ-018 Synchronized sel falling while in SHIFT SHALL return to IDLE without a commit.
REQ-019 tdo SHALL equal sr[0] registered, updated one cycle after each sr change.
REQ-020 err_clr SHALL clear both sticky flags; a set event in the same cycle wins over err_clr.

Reset
REQ-021 rst SHALL force FSM=IDLE, sr=0, bit_cnt=0, tdo=0, upd_data=0, upd_valid=0, short_err=0, ovf_err=0, and all synchronizer flops to 0.
REQ-022 Synchronized test_logic_reset high SHALL force FSM=IDLE, sr=0 and bit_cnt=0.
REQ-023 test_logic_reset SHALL leave upd_data, upd_valid and the error flags unchanged.
REQ-024 rst asserted mid-shift SHALL take effect the next clk edge; the first tck_rise after rst releases is handled per REQ-009..REQ-011.

Verification
REQ-025 DR_WIDTH=32, cap_data=0xA5A5_0F0F, capture, then 32 shifts with tdi for 0x1234_5678 LSB first, then update -> tdo shows 0xA5A5_0F0F LSB first; upd_valid=1, upd_data=0x1234_5678.
REQ-026 Capture, 31 shifts, update -> short_err=1, upd_valid stays 0; err_clr pulse -> short_err=0.
REQ-027 Two complete transactions (0x1111_1111 then 0x2222_2222) with upd_ready=0 -> upd_data=0x1111_1111, ovf_err=1; upd_ready=1 -> upd_valid drops.
REQ-028 upd_ready asserted exactly in the second transaction's COMMIT cycle -> upd_data=0x2222_2222, upd_valid stays 1, ovf_err=0.
REQ-029 test_logic_reset pulse after 10 shifts, then full 32-bit transaction -> correct word; a previously pending upd_valid is preserved.
REQ-030 tck toggling with ir_is_user=0 and capture/shift/update active -> no state change, tdo=0, upd_valid=0.
